// File: rtl/stream_utils_pkg.sv
// Shared stream types for the demux slice.
// Holds the packet-lock route FSM state encoding.
package stream_utils_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/stream_demux_if.sv
// Valid/ready stream bundle used between the demux and its slices.
// W carries the full beat, payload plus any sideband bits.
interface stream_demux_if #(
  parameter int W = 9
);

  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/stream_reg_slice.sv
// One-deep forward register slice with full-throughput handshake.
// Data is left unreset; it is only meaningful while valid is high.
module stream_reg_slice #(
  parameter int W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_demux_if.slave    s,
  stream_demux_if.master   m
);

  logic         valid_q;
  logic [W-1:0] data_q;
  logic         load;

  assign s.ready = !valid_q || m.ready;
  assign load    = s.valid && s.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
    end else if (m.ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      data_q <= s.data;
    end
  end

  assign m.valid = valid_q;
  assign m.data  = data_q;

endmodule

// File: rtl/stream_demux.sv
// 1-to-2 stream demux with a register slice per master output.
// STREAM_DEMUX_PKT_LOCK_EN holds the route for a whole packet.
module stream_demux
  import stream_utils_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          sel,
  input  logic [DW-1:0] s_data_i,
  input  logic          s_valid_i,
  input  logic          s_last_i,
  output logic          s_ready_o,
  output logic [DW-1:0] m0_data_o,
  output logic          m0_valid_o,
  output logic          m0_last_o,
  input  logic          m0_ready_i,
  output logic [DW-1:0] m1_data_o,
  output logic          m1_valid_o,
  output logic          m1_last_o,
  input  logic          m1_ready_i
);

  logic route;

  stream_demux_if #(.W(DW+1)) s0_in  ();
  stream_demux_if #(.W(DW+1)) s0_out ();
  stream_demux_if #(.W(DW+1)) s1_in  ();
  stream_demux_if #(.W(DW+1)) s1_out ();

  assign s0_in.data  = {s_last_i, s_data_i};
  assign s1_in.data  = {s_last_i, s_data_i};
  assign s0_in.valid = s_valid_i && !route;
  assign s1_in.valid = s_valid_i && route;

  // Only the active slice may grant the input.
  assign s_ready_o = route ? s1_in.ready : s0_in.ready;

`ifdef STREAM_DEMUX_PKT_LOCK_EN
  lock_state_e state_q, state_d;
  logic        route_q, route_d;
  logic        accept;

  assign accept = s_valid_i && s_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      route_q <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !s_last_i) begin
          state_d = LOCKED;
          route_d = sel;
        end
      end
      LOCKED: begin
        if (accept && s_last_i) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign route = (state_q == LOCKED) ? route_q : sel;
`else
  assign route = sel;
`endif

  stream_reg_slice #(.W(DW+1)) u_slice0 (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .s     (s0_in.slave),
    .m     (s0_out.master)
  );

  stream_reg_slice #(.W(DW+1)) u_slice1 (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .s     (s1_in.slave),
    .m     (s1_out.master)
  );

  assign s0_out.ready = m0_ready_i;
  assign s1_out.ready = m1_ready_i;

  assign m0_data_o  = s0_out.data[DW-1:0];
  assign m0_last_o  = s0_out.data[DW];
  assign m0_valid_o = s0_out.valid;
  assign m1_data_o  = s1_out.data[DW-1:0];
  assign m1_last_o  = s1_out.data[DW];
  assign m1_valid_o = s1_out.valid;

endmodule
